// File: rtl/evaluate_mob_sum_pkg.sv
// Shared constants, FSM encoding and adder-tree shape helpers for the mobility reduction stage.
package evaluate_mob_sum_pkg;

    localparam int unsigned MOB_TREE_FANIN = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_VALID = 2'd2
    } mob_state_e;

    // Number of operands present at tree level s (level 0 = the per-square inputs).
    function automatic int unsigned stage_count(int unsigned n, int unsigned s);
        int unsigned c;
        c = n;
        for (int unsigned i = 0; i < s; i++) begin
            c = (c + MOB_TREE_FANIN - 1) / MOB_TREE_FANIN;
        end
        return c;
    endfunction

    // max(1, ceil(log4(n)))
    function automatic int unsigned tree_stages(int unsigned n);
        int unsigned c;
        int unsigned s;
        c = n;
        s = 0;
        while (c > 1) begin
            c = (c + MOB_TREE_FANIN - 1) / MOB_TREE_FANIN;
            s++;
        end
        if (s == 0) begin
            s = 1;
        end
        return s;
    endfunction

    // Offset of the first node of level s inside the flattened node vector.
    function automatic int unsigned node_base(int unsigned n, int unsigned s);
        int unsigned b;
        b = 0;
        for (int unsigned i = 0; i < s; i++) begin
            b += stage_count(n, i);
        end
        return b;
    endfunction

endpackage

// File: rtl/evaluate_mob_sum_if.sv
// Board-valid, per-square score and summed-score signals between the evaluators and the summer.
interface evaluate_mob_sum_if #(
    parameter int unsigned EVAL_WIDTH   = 24,
    parameter int unsigned SQUARE_COUNT = 64
);
    logic                                 board_valid;
    logic [SQUARE_COUNT*EVAL_WIDTH-1:0]   mob_mg;
    logic [SQUARE_COUNT*EVAL_WIDTH-1:0]   mob_eg;
    logic signed [EVAL_WIDTH-1:0]         eval_mg;
    logic signed [EVAL_WIDTH-1:0]         eval_eg;
    logic                                 eval_valid;

    modport master (
        output board_valid, mob_mg, mob_eg,
        input  eval_mg, eval_eg, eval_valid
    );

    modport slave (
        input  board_valid, mob_mg, mob_eg,
        output eval_mg, eval_eg, eval_valid
    );
endinterface

// File: rtl/evaluate_mob_sum_mob_add4.sv
// Registered 4-input signed adder; one node of the mobility reduction tree.
module mob_add4 #(
    parameter int unsigned EVAL_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [EVAL_WIDTH-1:0] a,
    input  logic signed [EVAL_WIDTH-1:0] b,
    input  logic signed [EVAL_WIDTH-1:0] c,
    input  logic signed [EVAL_WIDTH-1:0] d,
    output logic signed [EVAL_WIDTH-1:0] sum
);

    // Two's-complement wrap is intended; the width check at the top keeps real sums in range.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else begin
            sum <= a + b + c + d;
        end
    end

endmodule

// File: rtl/evaluate_mob_sum.sv
// Sums per-square mobility scores through a registered 4-ary tree and tracks board_valid
// across the upstream plus tree latency to produce eval_valid.
module evaluate_mob_sum
    import evaluate_mob_sum_pkg::*;
#(
    parameter int unsigned EVAL_WIDTH       = 24,
    parameter int unsigned SQUARE_COUNT     = 64,
    parameter int unsigned UPSTREAM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    evaluate_mob_sum_if.slave bus
);

    localparam int unsigned TREE_STAGES = tree_stages(SQUARE_COUNT);
    localparam int unsigned LATENCY     = UPSTREAM_LATENCY + TREE_STAGES;
    localparam int unsigned CNT_W       = $clog2(LATENCY + 1);
    localparam int unsigned TOTAL_NODES = node_base(SQUARE_COUNT, TREE_STAGES + 1);

    if (SQUARE_COUNT < 1 || SQUARE_COUNT > 256) begin : g_bad_count
        $error("evaluate_mob_sum: SQUARE_COUNT must be in 1..256");
    end
    if (EVAL_WIDTH < $clog2(SQUARE_COUNT * 64) + 1) begin : g_bad_width
        $error("evaluate_mob_sum: EVAL_WIDTH too narrow for SQUARE_COUNT mobility scores");
    end

    // All tree levels flattened into one vector: level 0 = inputs, last node = result.
    logic [TOTAL_NODES*EVAL_WIDTH-1:0] nodes_mg;
    logic [TOTAL_NODES*EVAL_WIDTH-1:0] nodes_eg;

    assign nodes_mg[SQUARE_COUNT*EVAL_WIDTH-1:0] = bus.mob_mg;
    assign nodes_eg[SQUARE_COUNT*EVAL_WIDTH-1:0] = bus.mob_eg;

    for (genvar s = 0; s < TREE_STAGES; s++) begin : g_stage
        localparam int unsigned N_IN     = stage_count(SQUARE_COUNT, s);
        localparam int unsigned N_OUT    = stage_count(SQUARE_COUNT, s + 1);
        localparam int unsigned IN_BASE  = node_base(SQUARE_COUNT, s);
        localparam int unsigned OUT_BASE = node_base(SQUARE_COUNT, s + 1);

        for (genvar g = 0; g < N_OUT; g++) begin : g_group
            logic signed [EVAL_WIDTH-1:0] op_mg [MOB_TREE_FANIN];
            logic signed [EVAL_WIDTH-1:0] op_eg [MOB_TREE_FANIN];

            // Operands beyond the end of the level pad the last group with zero.
            for (genvar j = 0; j < MOB_TREE_FANIN; j++) begin : g_op
                if (g * MOB_TREE_FANIN + j < N_IN) begin : g_live
                    assign op_mg[j] = nodes_mg[(IN_BASE + g*MOB_TREE_FANIN + j)*EVAL_WIDTH +: EVAL_WIDTH];
                    assign op_eg[j] = nodes_eg[(IN_BASE + g*MOB_TREE_FANIN + j)*EVAL_WIDTH +: EVAL_WIDTH];
                end else begin : g_pad
                    assign op_mg[j] = '0;
                    assign op_eg[j] = '0;
                end
            end

            mob_add4 #(.EVAL_WIDTH(EVAL_WIDTH)) u_add_mg (
                .clk   (clk),
                .reset (reset),
                .a     (op_mg[0]),
                .b     (op_mg[1]),
                .c     (op_mg[2]),
                .d     (op_mg[3]),
                .sum   (nodes_mg[(OUT_BASE + g)*EVAL_WIDTH +: EVAL_WIDTH])
            );

            mob_add4 #(.EVAL_WIDTH(EVAL_WIDTH)) u_add_eg (
                .clk   (clk),
                .reset (reset),
                .a     (op_eg[0]),
                .b     (op_eg[1]),
                .c     (op_eg[2]),
                .d     (op_eg[3]),
                .sum   (nodes_eg[(OUT_BASE + g)*EVAL_WIDTH +: EVAL_WIDTH])
            );
        end
    end

    assign bus.eval_mg = nodes_mg[(TOTAL_NODES-1)*EVAL_WIDTH +: EVAL_WIDTH];
    assign bus.eval_eg = nodes_eg[(TOTAL_NODES-1)*EVAL_WIDTH +: EVAL_WIDTH];

    mob_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             valid;

    // Valid tracker: counts consecutive board_valid edges until the tree output matches the board.
    always_ff @(posedge clk) begin
        if (reset || !bus.board_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= CNT_W'(1);
                    if (LATENCY <= 1) begin
                        state <= ST_VALID;
                        valid <= 1'b1;
                    end else begin
                        state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt + CNT_W'(1) == CNT_W'(LATENCY)) begin
                        state <= ST_VALID;
                        valid <= 1'b1;
                    end
                end
                ST_VALID: begin
                    valid <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.eval_valid = valid;

endmodule
